reduction_arbiter: RTL

- Buffered round-robin scheduler that shares one reduction output channel among FAN_IN router ports.
- Each port owns a single-entry holding slot. The arbiter picks one full slot per cycle and drives a registered flit, valid and selector.
- Downstream uses a valid/ready handshake.
- Sits between the per-port input stages and the reduction/output stage of the collective router. It replaces fixed-priority selection with a fair, back-pressured schedule.

---
 rtl/reduction_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reduction_arbiter.sv
// Buffered round-robin scheduler sharing one reduction output channel
// among FAN_IN router ports. Each port owns a single-entry holding slot;
// one full slot is popped per cycle into a registered output flit with a
// valid/ready handshake downstream.
//
// Optional build macro: REDUCE_ARB_STATS_EN adds per-port saturating
// 16-bit grant counters on output grant_count.
module reduction_arbiter #(
    parameter int FAN_IN      = 6,
    parameter int ValidBitPos = 81,
    parameter int lg_numprocs = 3,
    localparam int ROUTE_LEN      = 3,
    localparam int FlitWidth      = ValidBitPos + 1,
    localparam int FlitChildWidth = FlitWidth + lg_numprocs
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [FlitChildWidth*FAN_IN-1:0] in,
    input  logic [FAN_IN-1:0]                in_valid,
    output logic [FAN_IN-1:0]                in_ready,
    output logic [FlitChildWidth-1:0]        out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ROUTE_LEN-1:0]             selector,
`ifdef REDUCE_ARB_STATS_EN
    output logic [16*FAN_IN-1:0]             grant_count,
`endif
    output logic [FAN_IN-1:0]                grant
);

    logic [FlitChildWidth-1:0] slot [FAN_IN];
    logic [FAN_IN-1:0]         full;
    logic [ROUTE_LEN-1:0]      ptr;
    logic [ROUTE_LEN-1:0]      winner;
    logic                      found;
    logic                      load;
    int                        scan_idx;

    assign load = !out_valid || out_ready;

    // Round-robin search: first full slot starting at ptr, wrapping at FAN_IN.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < FAN_IN; k++) begin
            scan_idx = int'(ptr) + k;
            if (scan_idx >= FAN_IN) begin
                scan_idx = scan_idx - FAN_IN;
            end
            if (!found && full[scan_idx]) begin
                found  = 1'b1;
                winner = ROUTE_LEN'(scan_idx);
            end
        end
    end

    // Pop strobe and slot-ready; a slot being popped can take a new flit the same cycle.
    always_comb begin
        grant = '0;
        if (!rst && load && found) begin
            grant[winner] = 1'b1;
        end
        in_ready = rst ? '0 : (~full | grant);
    end

    // Slot occupancy: a push wins over a pop on the same port.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= '0;
        end else begin
            for (int i = 0; i < FAN_IN; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    full[i] <= 1'b1;
                end else if (grant[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    // Slot payload capture; contents are only meaningful while full is set.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FAN_IN; i++) begin
            if (in_valid[i] && in_ready[i]) begin
                slot[i] <= in[i*FlitChildWidth +: FlitChildWidth];
            end
        end
    end

    // Output register and round-robin pointer; both hold while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
            selector  <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (found) begin
                out       <= slot[winner];
                out_valid <= 1'b1;
                selector  <= winner;
                ptr       <= (winner == ROUTE_LEN'(FAN_IN - 1)) ? '0 : winner + ROUTE_LEN'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef REDUCE_ARB_STATS_EN
    logic [15:0] grant_cnt [FAN_IN];

    // Per-port grant counters that stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FAN_IN; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FAN_IN; i++) begin
                if (grant[i] && grant_cnt[i] != 16'hFFFF) begin
                    grant_cnt[i] <= grant_cnt[i] + 16'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < FAN_IN; i++) begin
            grant_count[i*16 +: 16] = grant_cnt[i];
        end
    end
`endif

endmodule
